// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline register with an architectural flag register, a one-deep
// shadow copy for save/restore, and a saturating stall-cycle counter.
module ex_mem_buffer #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 11,
    parameter int FLAG_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] controlSignals_in,
    input  logic [DATA_W-1:0] aluResult_in,
    input  logic [DATA_W-1:0] storeData_in,
    input  logic [2:0]        writeAddr_in,
    input  logic              valid_in,
    input  logic [FLAG_W-1:0] aluFlags_in,
    input  logic [FLAG_W-1:0] flagEn_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              flagSave,
    input  logic              flagRestore,
    output logic [CTRL_W-1:0] controlSignals_out,
    output logic [DATA_W-1:0] aluResult_out,
    output logic [DATA_W-1:0] storeData_out,
    output logic [2:0]        writeAddr_out,
    output logic              valid_out,
    output logic [FLAG_W-1:0] flags_out,
    output logic [7:0]        stallCount
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_store;
    logic [2:0]        r_waddr;
    logic              r_valid;
    logic [FLAG_W-1:0] r_flags;
    logic [FLAG_W-1:0] r_shadow;
    logic [7:0]        r_stall_cnt;

    logic              w_load;
    logic              w_commit;
    logic [FLAG_W-1:0] w_flags_merged;
    logic              w_cnt_inc;

    assign w_load         = !flush && !stall;
    assign w_commit       = valid_in && w_load && !flagRestore;
    assign w_flags_merged = (r_flags & ~flagEn_in) | (aluFlags_in & flagEn_in);
    assign w_cnt_inc      = stall && !flush && (r_stall_cnt != 8'hFF);

    // Flush only kills valid/control; the data fields are don't-care once invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_ctrl  <= '0;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_ctrl  <= valid_in ? controlSignals_in : '0;
            r_valid <= valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu   <= '0;
            r_store <= '0;
            r_waddr <= '0;
        end else if (w_load) begin
            r_alu   <= aluResult_in;
            r_store <= storeData_in;
            r_waddr <= writeAddr_in;
        end
    end

    // Save and restore both read pre-edge values, so asserting both swaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags  <= '0;
            r_shadow <= '0;
        end else begin
            if (flagRestore)
                r_flags <= r_shadow;
            else if (w_commit)
                r_flags <= w_flags_merged;
            if (flagSave)
                r_shadow <= r_flags;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (w_cnt_inc)
            r_stall_cnt <= r_stall_cnt + 8'd1;
    end

    assign controlSignals_out = r_ctrl;
    assign aluResult_out      = r_alu;
    assign storeData_out      = r_store;
    assign writeAddr_out      = r_waddr;
    assign valid_out          = r_valid;
    assign flags_out          = r_flags;
    assign stallCount         = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed plus randomized bench for ex_mem_buffer against a cycle-level
// reference model of the pipeline register, flags, shadow and stall counter.
module tb_ex_mem_buffer;

    localparam int DW = 16;
    localparam int CW = 11;
    localparam int FW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] controlSignals_in;
    logic [DW-1:0] aluResult_in;
    logic [DW-1:0] storeData_in;
    logic [2:0]    writeAddr_in;
    logic          valid_in;
    logic [FW-1:0] aluFlags_in;
    logic [FW-1:0] flagEn_in;
    logic          stall;
    logic          flush;
    logic          flagSave;
    logic          flagRestore;
    logic [CW-1:0] controlSignals_out;
    logic [DW-1:0] aluResult_out;
    logic [DW-1:0] storeData_out;
    logic [2:0]    writeAddr_out;
    logic          valid_out;
    logic [FW-1:0] flags_out;
    logic [7:0]    stallCount;

    ex_mem_buffer #(.DATA_W(DW), .CTRL_W(CW), .FLAG_W(FW)) dut (
        .clk(clk), .rst(rst),
        .controlSignals_in(controlSignals_in), .aluResult_in(aluResult_in),
        .storeData_in(storeData_in), .writeAddr_in(writeAddr_in),
        .valid_in(valid_in), .aluFlags_in(aluFlags_in), .flagEn_in(flagEn_in),
        .stall(stall), .flush(flush), .flagSave(flagSave), .flagRestore(flagRestore),
        .controlSignals_out(controlSignals_out), .aluResult_out(aluResult_out),
        .storeData_out(storeData_out), .writeAddr_out(writeAddr_out),
        .valid_out(valid_out), .flags_out(flags_out), .stallCount(stallCount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [CW-1:0] m_ctrl;
    logic [DW-1:0] m_alu, m_store;
    logic [2:0]    m_waddr;
    logic          m_valid;
    logic [FW-1:0] m_flags, m_shadow;
    int            m_cnt;

    task automatic model_reset();
        m_ctrl = '0; m_alu = '0; m_store = '0; m_waddr = '0; m_valid = 1'b0;
        m_flags = '0; m_shadow = '0; m_cnt = 0;
    endtask

    task automatic model_edge();
        logic [FW-1:0] nf;
        nf = m_flags;
        if (flagRestore)
            nf = m_shadow;
        else if (valid_in && !stall && !flush)
            for (int i = 0; i < FW; i++)
                if (flagEn_in[i]) nf[i] = aluFlags_in[i];
        if (flagSave) m_shadow = m_flags;
        m_flags = nf;
        if (flush) begin
            m_valid = 1'b0; m_ctrl = '0;
        end else if (!stall) begin
            m_valid = valid_in;
            m_ctrl  = valid_in ? controlSignals_in : '0;
            m_alu   = aluResult_in;
            m_store = storeData_in;
            m_waddr = writeAddr_in;
        end
        if (stall && !flush) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".ctrl"},  32'(controlSignals_out), 32'(m_ctrl));
        chk({ph, ".alu"},   32'(aluResult_out),      32'(m_alu));
        chk({ph, ".store"}, 32'(storeData_out),      32'(m_store));
        chk({ph, ".waddr"}, 32'(writeAddr_out),      32'(m_waddr));
        chk({ph, ".valid"}, 32'(valid_out),          32'(m_valid));
        chk({ph, ".flags"}, 32'(flags_out),          32'(m_flags));
        chk({ph, ".cnt"},   32'(stallCount),         32'(m_cnt));
    endtask

    // One clock edge: model follows the inputs seen at the edge, then compare.
    task automatic step(input string ph);
        @(posedge clk);
        if (rst) model_edge();
        #1;
        check_all(ph);
    endtask

    task automatic set_pipe(input logic [CW-1:0] c, input logic [DW-1:0] a,
                            input logic [DW-1:0] s, input logic [2:0] w, input logic v);
        controlSignals_in = c; aluResult_in = a; storeData_in = s;
        writeAddr_in = w; valid_in = v;
    endtask

    task automatic set_ctl(input logic st, input logic fl, input logic sv, input logic rs);
        stall = st; flush = fl; flagSave = sv; flagRestore = rs;
    endtask

    initial begin
        rst = 1'b0;
        set_pipe('0, '0, '0, '0, 1'b0);
        aluFlags_in = '0; flagEn_in = '0;
        set_ctl(0, 0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b1;

        // Basic load
        set_pipe(11'h7FF, 16'h1234, 16'hABCD, 3'd5, 1'b1);
        step("load");
        chk("load.alu_const", 32'(aluResult_out), 32'h1234);
        chk("load.ctrl_const", 32'(controlSignals_out), 32'h7FF);

        // Invalid load zeroes control
        set_pipe(11'h155, 16'h0F0F, 16'h1111, 3'd2, 1'b0);
        step("inv_load");
        chk("inv_load.ctrl_const", 32'(controlSignals_out), 32'h0);
        set_pipe(11'h7FF, 16'h1234, 16'hABCD, 3'd5, 1'b1);
        step("reload");

        // Stall three edges with changing inputs, then stall+flush
        set_ctl(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            set_pipe(CW'(i + 1), DW'(16'h5000 + i), DW'(16'h6000 + i), 3'(i), 1'b1);
            step("stall");
        end
        chk("stall3.cnt_const", 32'(stallCount), 32'd3);
        chk("stall3.alu_hold", 32'(aluResult_out), 32'h1234);
        set_ctl(1, 1, 0, 0);
        step("stall_flush");
        chk("stall_flush.valid", 32'(valid_out), 32'd0);
        chk("stall_flush.cnt_const", 32'(stallCount), 32'd3);

        // Flag enables
        set_ctl(0, 0, 0, 0);
        set_pipe(11'h001, 16'h0001, 16'h0002, 3'd1, 1'b1);
        aluFlags_in = 3'b111; flagEn_in = 3'b101;
        step("flag_en");
        chk("flag_en.const", 32'(flags_out), 32'h5);
        valid_in = 1'b0;
        step("flag_inv");
        chk("flag_inv.const", 32'(flags_out), 32'h5);

        // Save / restore sequence
        valid_in = 1'b1; aluFlags_in = 3'b011; flagEn_in = 3'b111;
        step("flags011");
        valid_in = 1'b0; set_ctl(0, 0, 1, 0);
        step("save");
        set_ctl(0, 0, 0, 0); valid_in = 1'b1; aluFlags_in = 3'b100;
        step("flags100");
        set_ctl(0, 0, 0, 1); aluFlags_in = 3'b111;
        step("restore");
        chk("restore.const", 32'(flags_out), 32'h3);
        set_ctl(0, 0, 0, 0); aluFlags_in = 3'b100;
        step("flags100b");
        set_ctl(0, 0, 1, 1); valid_in = 1'b0;
        step("swap");
        chk("swap.flags_const", 32'(flags_out), 32'h3);
        set_ctl(0, 0, 0, 1);
        step("swap_chk");
        chk("swap.shadow_const", 32'(flags_out), 32'h4);
        set_ctl(0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_pipe(CW'($urandom), DW'($urandom), DW'($urandom), 3'($urandom),
                     1'($urandom_range(0, 3) != 0));
            aluFlags_in = FW'($urandom); flagEn_in = FW'($urandom);
            set_ctl($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            step("rand");
        end

        // Saturation
        set_ctl(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) step("sat");
        chk("sat.cnt_const", 32'(stallCount), 32'd255);

        // Async reset mid-stall, with save/restore pending
        set_ctl(1, 0, 1, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        for (int i = 0; i < 2; i++) begin
            set_pipe(CW'($urandom), DW'($urandom), DW'($urandom), 3'($urandom), 1'b1);
            aluFlags_in = 3'b111; flagEn_in = 3'b111;
            step("rst_hold");
        end
        @(negedge clk);
        rst = 1'b1;
        set_ctl(0, 0, 0, 0);
        set_pipe(11'h2AA, 16'hBEEF, 16'hCAFE, 3'd6, 1'b1);
        aluFlags_in = 3'b111; flagEn_in = 3'b111;
        step("post_rst");
        chk("post_rst.alu_const", 32'(aluResult_out), 32'hBEEF);
        set_ctl(0, 0, 0, 1); valid_in = 1'b0;
        step("post_rst_restore");
        chk("post_rst.shadow_const", 32'(flags_out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_buffer.md
EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DATA_W, 16, data width
- CTRL_W, 11, control bundle width
- FLAG_W, 3, flag width: bit0 Z, bit1 N, bit2 C
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous active-low reset
- controlSignals_in  in  CTRL_W  control bundle from Execute
- aluResult_in  in  DATA_W  Execute ALU result
- storeData_in  in  DATA_W  second read operand, forwarded for stores
- writeAddr_in  in  3  destination register index
- valid_in  in  1  Execute holds a real instruction
- aluFlags_in  in  FLAG_W  flags computed by the ALU
- flagEn_in  in  FLAG_W  per-bit flag write enable
- stall  in  1  hold register contents
- flush  in  1  kill the incoming instruction
- flagSave  in  1  copy the flag register to the shadow register
- flagRestore  in  1  load the flag register from the shadow register
- controlSignals_out  out  CTRL_W  registered control bundle to Memory
- aluResult_out  out  DATA_W  registered ALU result
- storeData_out  out  DATA_W  registered store data
- writeAddr_out  out  3  registered destination index
- valid_out  out  1  Memory stage holds a real instruction
- flags_out  out  FLAG_W  architectural flag register
- stallCount  out  8  saturating count of stalled cycles

Function
REQ-003 Pipeline latency shall be exactly one clk cycle from the *_in ports to the matching *_out ports.
REQ-004 Each rising edge shall select one action, in priority order flush > stall > load:
- flush=1: valid_out=0 and controlSignals_out=0; aluResult_out, storeData_out and writeAddr_out hold their values.
- flush=0, stall=1: all pipeline outputs hold.
- Otherwise: all pipeline outputs load their *_in values, and valid_out takes valid_in.
REQ-005 When valid_in=0 and a load occurs, controlSignals_out shall load 0 regardless of controlSignals_in.
REQ-006 A flag commit shall occur only on an edge where valid_in=1, stall=0, flush=0 and flagRestore=0.
REQ-007 On a commit, each flag bit i shall take aluFlags_in[i] if flagEn_in[i]=1 and shall otherwise hold.
REQ-008 flagRestore=1 shall load the flag register from the shadow register, regardless of stall and flush, and shall suppress any commit on that edge.
REQ-009 flagSave=1 shall copy the flag register's pre-edge value to the shadow register.
- flagSave and flagRestore asserted together: the shadow register captures the old flag value and the flag register takes the old shadow value (swap).
REQ-010 flags_out shall be the flag register itself, with no combinational bypass from aluFlags_in.
REQ-011 stallCount shall increment on each edge with stall=1 and flush=0, shall saturate at 255, and shall never wrap.
REQ-012 The block shall contain no combinational path from any input to any output.

Reset
REQ-013 rst=0 shall immediately, without waiting for a clock edge, force to 0: all pipeline outputs, valid_out, flags_out, the shadow register and stallCount.
REQ-014 While rst=0, all clk edges shall be ignored.
REQ-015 Operation shall resume on the first rising edge after rst returns to 1.
REQ-016 A reset asserted during a stall or during a save/restore shall leave no partial state behind.

Verification
REQ-017 Load: valid_in=1, aluResult_in=0x1234, writeAddr_in=5, controlSignals_in=0x7FF -> after one edge, aluResult_out=0x1234, writeAddr_out=5, controlSignals_out=0x7FF, valid_out=1.
REQ-018 Stall then flush:
- stall=1 for 3 edges with changing inputs -> outputs hold and stallCount=3.
- Then stall=1 and flush=1 together -> valid_out=0, controlSignals_out=0, stallCount stays 3.
REQ-019 Flag enables:
- flags=000, aluFlags_in=111, flagEn_in=101, valid_in=1 -> flags_out=101.
- Same inputs with valid_in=0 -> flags_out unchanged.
REQ-020 Save and restore:
- flags=011, flagSave -> shadow=011.
- Commit makes flags=100.
- flagRestore together with a valid commit of 111 -> flags_out=011.
- flagSave and flagRestore together with flags=100, shadow=011 -> flags=011, shadow=100.
REQ-021 Saturation: stall held for 300 edges -> stallCount=255.
REQ-022 Asynchronous reset: rst driven to 0 between clock edges mid-stall -> all outputs 0 before the next edge; the first edge after rst=1 loads normally.
